// File: rtl/i2s_capture_sequencer_if.sv
// Bus bundle between the I2S capture sequencer, the i2s receiver core and the AHB wrapper.
// The chsel signal exists only when I2S_CAP_CHSEL_EN is defined.
interface i2s_capture_sequencer_if #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 12
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             start;
  logic             stop;
  logic             cont;
  logic [LEN_W-1:0] frame_len;
  logic             flush;
  logic             done_clr;
  logic             i2s_en;
  logic             smp_valid;
  logic [31:0]      smp_data;
  logic             smp_ws;
  logic             rd_pop;
  logic [31:0]      rd_data;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_empty;
  logic             busy;
  logic             frame_done;
  logic             overflow;
  logic             irq;
`ifdef I2S_CAP_CHSEL_EN
  logic             chsel;
`endif

  modport slave (
`ifdef I2S_CAP_CHSEL_EN
    input  chsel,
`endif
    input  start, stop, cont, frame_len, flush, done_clr,
    input  smp_valid, smp_data, smp_ws, rd_pop,
    output i2s_en, rd_data, fifo_level, fifo_empty, busy, frame_done, overflow, irq
  );

  modport master (
`ifdef I2S_CAP_CHSEL_EN
    output chsel,
`endif
    output start, stop, cont, frame_len, flush, done_clr,
    output smp_valid, smp_data, smp_ws, rd_pop,
    input  i2s_en, rd_data, fifo_level, fifo_empty, busy, frame_done, overflow, irq
  );
endinterface

// File: rtl/i2s_capture_sequencer.sv
// I2S capture sequencer: warm-up discard, framed capture into a FWFT FIFO, sticky flags.
// Define I2S_CAP_CHSEL_EN to capture only samples whose word select matches chsel.
module i2s_capture_sequencer #(
  parameter int DEPTH  = 64,
  parameter int LEN_W  = 12,
  parameter int WARMUP = 16
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  i2s_capture_sequencer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  typedef enum logic [1:0] {IDLE, WARM, CAPT} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [WARM_W-1:0] warm_cnt;
  logic             i2s_en;
  logic             busy;
  logic             frame_done;
  logic             overflow;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [LVL_W-1:0] level;
  logic [31:0]      rd_data;

  logic hit;
  logic push_req;
  logic push_ok;
  logic pop_ok;
  logic full;
  logic frame_end;
  logic start_ok;

`ifndef I2S_CAP_CHSEL_EN
  logic unused_ws;
  assign unused_ws = bus.smp_ws;
`endif

  always_comb begin
`ifdef I2S_CAP_CHSEL_EN
    hit = bus.smp_valid && (bus.smp_ws == bus.chsel);
`else
    hit = bus.smp_valid;
`endif
    cnt_inc   = cnt + 1'b1;
    start_ok  = (state == IDLE) && bus.start && (bus.frame_len != '0) && !bus.stop;
    push_req  = (state == CAPT) && hit && !bus.stop;
    frame_end = push_req && (cnt_inc == len);
    full      = (level == LVL_W'(DEPTH));
    pop_ok    = bus.rd_pop && (level != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    push_ok   = push_req && (!full || pop_ok);
    rd_next   = rd_ptr + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      warm_cnt   <= '0;
      i2s_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (frame_end)
        frame_done <= 1'b1;
      else if (bus.done_clr || start_ok)
        frame_done <= 1'b0;

      if (bus.stop) begin
        state  <= IDLE;
        cnt    <= '0;
        i2s_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_ok) begin
              len      <= bus.frame_len;
              cnt      <= '0;
              warm_cnt <= '0;
              i2s_en   <= 1'b1;
              busy     <= 1'b1;
              if (WARMUP == 0) state <= CAPT;
              else             state <= WARM;
            end
          end
          WARM: begin
            if (hit) begin
              if (int'(warm_cnt) == WARMUP - 1) begin
                state    <= CAPT;
                warm_cnt <= '0;
              end else begin
                warm_cnt <= warm_cnt + 1'b1;
              end
            end
          end
          CAPT: begin
            // cnt advances even when the FIFO drops the sample, keeping frame timing
            if (hit) begin
              if (cnt_inc == len) begin
                cnt <= '0;
                if (!bus.cont) begin
                  state  <= IDLE;
                  i2s_en <= 1'b0;
                  busy   <= 1'b0;
                end
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          default: begin
            state  <= IDLE;
            i2s_en <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr   <= wr_ptr;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_next;
      if (push_req && !push_ok) overflow <= 1'b1;

      if (push_ok && !pop_ok)
        level <= level + 1'b1;
      else if (pop_ok && !push_ok)
        level <= level - 1'b1;

      // Registered head: follows the next entry, or the incoming sample when it becomes the head
      if (pop_ok) begin
        if (level > LVL_W'(1))
          rd_data <= mem[rd_next];
        else if (push_ok)
          rd_data <= bus.smp_data;
      end else if ((level == '0) && push_ok) begin
        rd_data <= bus.smp_data;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok && !bus.flush)
      mem[wr_ptr] <= bus.smp_data;
  end

  assign bus.i2s_en     = i2s_en;
  assign bus.busy       = busy;
  assign bus.rd_data    = rd_data;
  assign bus.fifo_level = level;
  assign bus.fifo_empty = (level == '0);
  assign bus.frame_done = frame_done;
  assign bus.overflow   = overflow;
  assign bus.irq        = frame_done | overflow;
endmodule
